// File: rtl/reg_status_table.sv
// ---------------------------------------------------------------------------
// reg_status_table
//
// Register status (rename) table for an out-of-order core.
// For each architectural register x1..x31 it records whether the register is
// waiting on an in-flight ROB entry and which ROB tag will produce it.
// x0 is hard-wired to "not busy" and ignores issue and commit.
//
// Optional feature (compile-time macro COMMIT_BYPASS_EN):
//   When defined, a source query that hits the register being retired in the
//   same cycle reports "not busy" and forwards the committing value directly.
//   When undefined, fwd_hit/fwd_val read 0 and busy clears one cycle after
//   the commit, so the consumer reads the register file instead.
//
// Ports
//   clk_in          rising-edge clock
//   rst_in          asynchronous active-high reset
//   rdy_in          global stall; all state holds while low
//   flush_pipline   mispredict flush; clears every pending tag
//   is_issuing      dispatcher allocates a ROB entry writing issue_rd_id
//   issue_rd_id     destination register of the issuing instruction
//   issue_rob_id    ROB tag of the issuing instruction
//   is_committing   ROB retires an entry this cycle
//   commit_rd_id    destination register of the retiring entry
//   commit_rob_id   ROB tag of the retiring entry
//   commit_val      result value of the retiring entry
//   rsN_reg_id      source register queries (N = 1, 2)
//   rsN_busy        source waits on a ROB result
//   rsN_rob_id      producer tag, 0 when not busy
//   rsN_fwd_hit     commit bypass valid
//   rsN_fwd_val     bypassed value, 0 when no hit
//   busy_count      number of busy registers (0..31)
// ---------------------------------------------------------------------------
module reg_status_table #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_pipline,
    input  logic                 is_issuing,
    input  logic [4:0]           issue_rd_id,
    input  logic [ROB_WIDTH-1:0] issue_rob_id,
    input  logic                 is_committing,
    input  logic [4:0]           commit_rd_id,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [31:0]          commit_val,
    input  logic [4:0]           rs1_reg_id,
    input  logic [4:0]           rs2_reg_id,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_WIDTH-1:0] rs1_rob_id,
    output logic [ROB_WIDTH-1:0] rs2_rob_id,
    output logic                 rs1_fwd_hit,
    output logic                 rs2_fwd_hit,
    output logic [31:0]          rs1_fwd_val,
    output logic [31:0]          rs2_fwd_val,
    output logic [5:0]           busy_count
);

    localparam int NUM_REGS = 32;

    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [ROB_WIDTH-1:0] tag_q [NUM_REGS];
    logic [ROB_WIDTH-1:0] tag_d [NUM_REGS];
    logic [5:0]           busy_count_q, busy_count_d;

    // Qualified events for this cycle.
    logic issue_ok;      // issue will take effect on the next edge
    logic commit_ok;     // commit matches the live producer tag
    logic commit_clear;  // commit actually clears (not overridden by issue)
    logic issue_sets;    // issue turns a non-busy register busy

    always_comb begin
        issue_ok     = rdy_in && !flush_pipline && is_issuing && (issue_rd_id != 5'd0);
        // A commit only counts when the register is still waiting on exactly
        // this tag; a newer issue to the same register has replaced the tag.
        commit_ok    = rdy_in && !flush_pipline && is_committing &&
                       (commit_rd_id != 5'd0) && busy_q[commit_rd_id] &&
                       (tag_q[commit_rd_id] == commit_rob_id);
        commit_clear = commit_ok && !(issue_ok && (issue_rd_id == commit_rd_id));
        issue_sets   = issue_ok && !busy_q[issue_rd_id];
    end

    // NOTE: combinational next-state logic uses blocking assignments and
    // starts from a full default so no latch is inferred on any path.
    always_comb begin
        busy_d       = busy_q;
        tag_d        = tag_q;
        busy_count_d = busy_count_q;

        if (rdy_in) begin
            if (flush_pipline) begin
                busy_d       = '0;
                busy_count_d = '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    tag_d[i] = '0;
                end
            end else begin
                // Commit first, then issue, so a same-register issue wins.
                if (commit_clear) begin
                    busy_d[commit_rd_id] = 1'b0;
                    tag_d[commit_rd_id]  = '0;
                end
                if (issue_ok) begin
                    busy_d[issue_rd_id] = 1'b1;
                    tag_d[issue_rd_id]  = issue_rob_id;
                end
                // Count only changes on real busy transitions, so it is
                // bounded by the number of busy registers and cannot wrap.
                unique case ({issue_sets, commit_clear})
                    2'b10:   busy_count_d = busy_count_q + 6'd1;
                    2'b01:   busy_count_d = busy_count_q - 6'd1;
                    default: busy_count_d = busy_count_q;
                endcase
            end
        end

        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    // NOTE: the table is a small flop array, not a RAM, so it is reset
    // explicitly; a flush or reset must leave no stale busy bits behind.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            tag_q        <= tag_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Query ports: purely combinational from stored state.
    always_comb begin
`ifdef COMMIT_BYPASS_EN
        rs1_fwd_hit = commit_ok && (rs1_reg_id == commit_rd_id);
        rs2_fwd_hit = commit_ok && (rs2_reg_id == commit_rd_id);
`else
        rs1_fwd_hit = 1'b0;
        rs2_fwd_hit = 1'b0;
`endif
        rs1_busy    = busy_q[rs1_reg_id] && !rs1_fwd_hit;
        rs2_busy    = busy_q[rs2_reg_id] && !rs2_fwd_hit;
        rs1_rob_id  = rs1_busy ? tag_q[rs1_reg_id] : '0;
        rs2_rob_id  = rs2_busy ? tag_q[rs2_reg_id] : '0;
        rs1_fwd_val = rs1_fwd_hit ? commit_val : 32'd0;
        rs2_fwd_val = rs2_fwd_hit ? commit_val : 32'd0;
    end

    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_status_table.sv
// ---------------------------------------------------------------------------
// tb_reg_status_table
//
// Self-checking bench for reg_status_table. A behavioural model (per-register
// busy flags and tags, busy count taken as a population count) is compared
// against the DUT on every falling edge; directed steps additionally pin
// hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_reg_status_table;

    localparam int RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          flush_pipline;
    logic          is_issuing;
    logic [4:0]    issue_rd_id;
    logic [RW-1:0] issue_rob_id;
    logic          is_committing;
    logic [4:0]    commit_rd_id;
    logic [RW-1:0] commit_rob_id;
    logic [31:0]   commit_val;
    logic [4:0]    rs1_reg_id, rs2_reg_id;
    logic          rs1_busy, rs2_busy;
    logic [RW-1:0] rs1_rob_id, rs2_rob_id;
    logic          rs1_fwd_hit, rs2_fwd_hit;
    logic [31:0]   rs1_fwd_val, rs2_fwd_val;
    logic [5:0]    busy_count;

    int n_tests = 0;
    int n_fail  = 0;

    reg_status_table #(.ROB_WIDTH(RW)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .is_issuing    (is_issuing),
        .issue_rd_id   (issue_rd_id),
        .issue_rob_id  (issue_rob_id),
        .is_committing (is_committing),
        .commit_rd_id  (commit_rd_id),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .rs1_reg_id    (rs1_reg_id),
        .rs2_reg_id    (rs2_reg_id),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_rob_id    (rs1_rob_id),
        .rs2_rob_id    (rs2_rob_id),
        .rs1_fwd_hit   (rs1_fwd_hit),
        .rs2_fwd_hit   (rs2_fwd_hit),
        .rs1_fwd_val   (rs1_fwd_val),
        .rs2_fwd_val   (rs2_fwd_val),
        .busy_count    (busy_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_busy [32];
    logic [RW-1:0] m_tag  [32];

    function automatic bit commit_qualifies();
        return rdy_in && !flush_pipline && is_committing && commit_rd_id != 5'd0 &&
               m_busy[commit_rd_id] && m_tag[commit_rd_id] == commit_rob_id;
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] <= 1'b0;
                m_tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (flush_pipline) begin
                for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
            end else begin
                if (commit_qualifies()) m_busy[commit_rd_id] <= 1'b0;
                // Later nonblocking write wins: issue overrides commit.
                if (is_issuing && issue_rd_id != 5'd0) begin
                    m_busy[issue_rd_id] <= 1'b1;
                    m_tag[issue_rd_id]  <= issue_rob_id;
                end
            end
        end
    end

    function automatic bit exp_hit(input logic [4:0] id);
`ifdef COMMIT_BYPASS_EN
        return commit_qualifies() && id == commit_rd_id;
`else
        return (id == 5'd31) && 1'b0 ? 1'b1 : 1'b0;
`endif
    endfunction

    function automatic bit exp_busy(input logic [4:0] id);
        return m_busy[id] && !exp_hit(id);
    endfunction

    function automatic logic [RW-1:0] exp_rob(input logic [4:0] id);
        return exp_busy(id) ? m_tag[id] : '0;
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] id);
        return exp_hit(id) ? commit_val : 32'd0;
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // Compare process: outputs are meaningful whenever reset is released.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            check("mdl_rs1_busy",    32'(rs1_busy),    32'(exp_busy(rs1_reg_id)));
            check("mdl_rs2_busy",    32'(rs2_busy),    32'(exp_busy(rs2_reg_id)));
            check("mdl_rs1_rob_id",  32'(rs1_rob_id),  32'(exp_rob(rs1_reg_id)));
            check("mdl_rs2_rob_id",  32'(rs2_rob_id),  32'(exp_rob(rs2_reg_id)));
            check("mdl_rs1_fwd_hit", 32'(rs1_fwd_hit), 32'(exp_hit(rs1_reg_id)));
            check("mdl_rs2_fwd_hit", 32'(rs2_fwd_hit), 32'(exp_hit(rs2_reg_id)));
            check("mdl_rs1_fwd_val", rs1_fwd_val,      exp_val(rs1_reg_id));
            check("mdl_rs2_fwd_val", rs2_fwd_val,      exp_val(rs2_reg_id));
            check("mdl_busy_count",  32'(busy_count),  32'(exp_count()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rdy_in        = 1'b1;
        flush_pipline = 1'b0;
        is_issuing    = 1'b0;
        issue_rd_id   = '0;
        issue_rob_id  = '0;
        is_committing = 1'b0;
        commit_rd_id  = '0;
        commit_rob_id = '0;
        commit_val    = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RW-1:0] tag);
        is_issuing   = 1'b1;
        issue_rd_id  = rd;
        issue_rob_id = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [RW-1:0] tag, input logic [31:0] v);
        is_committing = 1'b1;
        commit_rd_id  = rd;
        commit_rob_id = tag;
        commit_val    = v;
    endtask

    initial begin
        idle();
        rs1_reg_id = 5'd5;
        rs2_reg_id = 5'd5;
        rst_in     = 1'b0;
        #2 rst_in  = 1'b1;
        #1;
        check("rst_busy",       32'(rs1_busy),    32'd0);
        check("rst_rob_id",     32'(rs1_rob_id),  32'd0);
        check("rst_fwd_hit",    32'(rs2_fwd_hit), 32'd0);
        check("rst_fwd_val",    rs2_fwd_val,      32'd0);
        check("rst_busy_count", 32'(busy_count),  32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        tick();

        // Issue x5 tag 3.
        issue(5'd5, 4'd3);
        tick();
        idle();
        settle();
        check("iss_x5_busy",  32'(rs1_busy),   32'd1);
        check("iss_x5_rob",   32'(rs1_rob_id), 32'd3);
        check("iss_x5_count", 32'(busy_count), 32'd1);

        // Commit x5 with stale tag 2: no effect, no bypass.
        commit(5'd5, 4'd2, 32'h1234);
        settle();
        check("stale_no_fwd", 32'(rs2_fwd_hit), 32'd0);
        check("stale_busy",   32'(rs2_busy),    32'd1);
        tick();
        idle();
        settle();
        check("stale_keep_busy", 32'(rs1_busy),   32'd1);
        check("stale_keep_rob",  32'(rs1_rob_id), 32'd3);

        // Commit x5 tag 3 with value 0xDEADBEEF; query in the same cycle.
        commit(5'd5, 4'd3, 32'hDEADBEEF);
        settle();
`ifdef COMMIT_BYPASS_EN
        check("byp_busy", 32'(rs2_busy),    32'd0);
        check("byp_hit",  32'(rs2_fwd_hit), 32'd1);
        check("byp_val",  rs2_fwd_val,      32'hDEADBEEF);
`else
        check("byp_busy", 32'(rs2_busy),    32'd1);
        check("byp_hit",  32'(rs2_fwd_hit), 32'd0);
        check("byp_val",  rs2_fwd_val,      32'd0);
`endif
        tick();
        idle();
        settle();
        check("cmt_x5_busy",  32'(rs1_busy),   32'd0);
        check("cmt_x5_count", 32'(busy_count), 32'd0);

        // Same-edge issue x7 tag 4 and commit x7 tag 1: issue wins.
        issue(5'd7, 4'd1);
        tick();
        idle();
        issue(5'd7, 4'd4);
        commit(5'd7, 4'd1, 32'h77);
        tick();
        idle();
        rs1_reg_id = 5'd7;
        settle();
        check("iss_win_busy",  32'(rs1_busy),   32'd1);
        check("iss_win_rob",   32'(rs1_rob_id), 32'd4);
        check("iss_win_count", 32'(busy_count), 32'd1);

        // Issue x8 and commit x7 on the same edge: both apply.
        issue(5'd8, 4'd5);
        commit(5'd7, 4'd4, 32'h88);
        tick();
        idle();
        rs2_reg_id = 5'd8;
        settle();
        check("both_x7_free", 32'(rs1_busy),   32'd0);
        check("both_x8_busy", 32'(rs2_busy),   32'd1);
        check("both_x8_rob",  32'(rs2_rob_id), 32'd5);
        check("both_count",   32'(busy_count), 32'd1);

        // Ten more busy registers, then flush with a simultaneous issue.
        for (int i = 10; i < 20; i++) begin
            issue(5'(i), 4'(i));
            tick();
        end
        idle();
        settle();
        check("ten_count", 32'(busy_count), 32'd11);
        flush_pipline = 1'b1;
        issue(5'd9, 4'd2);
        tick();
        idle();
        rs1_reg_id = 5'd9;
        rs2_reg_id = 5'd15;
        settle();
        check("flush_x9",    32'(rs1_busy),   32'd0);
        check("flush_x15",   32'(rs2_busy),   32'd0);
        check("flush_count", 32'(busy_count), 32'd0);

        // Issue to x0 is ignored.
        issue(5'd0, 4'd2);
        rs1_reg_id = 5'd0;
        tick();
        idle();
        settle();
        check("x0_busy",  32'(rs1_busy),   32'd0);
        check("x0_count", 32'(busy_count), 32'd0);

        // rdy_in low freezes: issue x3 is lost.
        rdy_in = 1'b0;
        issue(5'd3, 4'd6);
        rs1_reg_id = 5'd3;
        tick();
        idle();
        settle();
        check("stall_x3",    32'(rs1_busy),   32'd0);
        check("stall_count", 32'(busy_count), 32'd0);

        // Query during issue reports pre-issue state.
        issue(5'd3, 4'd6);
        settle();
        check("pre_issue_busy", 32'(rs1_busy), 32'd0);
        tick();
        idle();
        settle();
        check("post_issue_busy", 32'(rs1_busy),   32'd1);
        check("post_issue_rob",  32'(rs1_rob_id), 32'd6);

        // Matching commit while stalled: no bypass, no clear.
        rdy_in = 1'b0;
        commit(5'd3, 4'd6, 32'h33);
        settle();
        check("stall_cmt_hit", 32'(rs1_fwd_hit), 32'd0);
        tick();
        idle();
        settle();
        check("stall_cmt_busy", 32'(rs1_busy), 32'd1);

        // Reset pulsed between edges clears immediately.
        rst_in = 1'b1;
        #1;
        check("mid_rst_count", 32'(busy_count), 32'd0);
        check("mid_rst_busy",  32'(rs1_busy),   32'd0);
        rst_in = 1'b0;
        tick();

        // Fill every register (count reaches its maximum of 31).
        for (int i = 1; i < 32; i++) begin
            issue(5'(i), 4'(i));
            rs1_reg_id = 5'(i);
            rs2_reg_id = 5'(i - 1);
            tick();
        end
        idle();
        settle();
        check("full_count", 32'(busy_count), 32'd31);

        // Retire the odd registers with matching tags; rs2 watches each one.
        for (int i = 1; i < 32; i += 2) begin
            commit(5'(i), 4'(i), 32'(i * 32'h0101_0101));
            rs2_reg_id = 5'(i);
            tick();
        end
        idle();
        settle();
        check("half_count", 32'(busy_count), 32'd15);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
